iot_event_encoder: RTL

//  Producer side of the active-device monitor interface. Watches N_DEV

---
 rtl/iot_mon_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/iot_event_encoder.sv | 99 +++++++++
 3 files changed

// File: rtl/iot_mon_pkg.sv
// Shared constants for the active-device monitor interface.
// Event direction encoding and the device-index width helper live here.
package iot_mon_pkg;

   localparam int unsigned N_DEV_DFLT       = 8;
   localparam int unsigned SYNC_STAGES_DFLT = 2;

   localparam logic EV_ON  = 1'b1;
   localparam logic EV_OFF = 1'b0;

   // Index width for n devices; never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping from N-1 back to 0. The pointer register is owned by the caller.
module rr_arbiter
   import iot_mon_pkg::*;
#(
   parameter int unsigned N = N_DEV_DFLT,
   localparam int unsigned IdxW = id_width(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IdxW-1:0] ptr,
   output logic            gnt_valid,
   output logic [IdxW-1:0] gnt_idx
);

   logic [IdxW:0] cand;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!gnt_valid) begin
            // ptr < N and k < N, so one conditional subtract performs the wrap.
            cand = {1'b0, ptr} + (IdxW + 1)'(k);
            if (cand >= (IdxW + 1)'(N)) begin
               cand = cand - (IdxW + 1)'(N);
            end
            if (req[cand[IdxW-1:0]]) begin
               gnt_valid = 1'b1;
               gnt_idx   = cand[IdxW-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/iot_event_encoder.sv
// Serialises on/off transitions of asynchronous device status lines into one
// change/on_off/dev_id event per cycle; unserviced transitions stay pending.
module iot_event_encoder
   import iot_mon_pkg::*;
#(
   parameter int unsigned N_DEV       = N_DEV_DFLT,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DFLT,
   localparam int unsigned ID_W = id_width(N_DEV)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_DEV-1:0] dev_status,
   input  logic             hold,
   output logic             change,
   output logic             on_off,
   output logic [ID_W-1:0]  dev_id,
   output logic             busy
);

   logic [SYNC_STAGES-1:0][N_DEV-1:0] sync_q, sync_d;
   logic [N_DEV-1:0]                  reported_q, reported_d;
   logic [N_DEV-1:0]                  sync_last;
   logic [N_DEV-1:0]                  pending;
   logic [ID_W-1:0]                   ptr_q, ptr_d;
   logic [ID_W-1:0]                   dev_id_q, dev_id_d;
   logic                              change_q, change_d;
   logic                              on_off_q, on_off_d;
   logic                              busy_q, busy_d;
   logic                              gnt_valid;
   logic [ID_W-1:0]                   gnt_idx;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = dev_status;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   assign sync_last = sync_q[SYNC_STAGES-1];
   // A device whose state returned to its last reported value is not pending,
   // so on->off->on glitches between services never reach the monitor.
   assign pending   = sync_last ^ reported_q;

   rr_arbiter #(
      .N (N_DEV)
   ) u_rr_arbiter (
      .req       (pending),
      .ptr       (ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      reported_d = reported_q;
      ptr_d      = ptr_q;
      dev_id_d   = dev_id_q;
      on_off_d   = on_off_q;
      change_d   = 1'b0;
      busy_d     = |pending;
      if (!hold && gnt_valid) begin
         change_d            = 1'b1;
         on_off_d            = sync_last[gnt_idx];
         dev_id_d            = gnt_idx;
         reported_d[gnt_idx] = sync_last[gnt_idx];
         if (gnt_idx == ID_W'(N_DEV - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = gnt_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '0;
         reported_q <= '0;
         ptr_q      <= '0;
         dev_id_q   <= '0;
         change_q   <= 1'b0;
         on_off_q   <= EV_OFF;
         busy_q     <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         reported_q <= reported_d;
         ptr_q      <= ptr_d;
         dev_id_q   <= dev_id_d;
         change_q   <= change_d;
         on_off_q   <= on_off_d;
         busy_q     <= busy_d;
      end
   end

   assign change = change_q;
   assign on_off = on_off_q;
   assign dev_id = dev_id_q;
   assign busy   = busy_q;

endmodule
